// File: rtl/bus_arbiter.sv
// N-driver arbiter for the BrainForge8 system bus: BR/BA ownership handshake,
// fixed-priority or round-robin winner selection, hold limit with lock override.
module bus_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 16,
    parameter int unsigned MODE     = 0,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    REQ,
    input  logic [N-1:0]    LOCK,
    input  logic [N*DW-1:0] WDATA,
    input  logic [N*AW-1:0] ADDR,
    input  logic [N-1:0]    WR,
    input  logic [N-1:0]    IFETCH,
    output logic [N-1:0]    GNT,
    output logic [DW-1:0]   RDATA,
    input  logic [DW-1:0]   D_I,
    output logic [DW-1:0]   D_O,
    output logic            D_OE,
    output logic [AW-1:0]   A_O,
    output logic            A_OE,
    output logic            RW_O,
    output logic            FI_O,
    output logic            DT_O,
    output logic            BR,
    input  logic            BA
);

    localparam int unsigned IW = (N < 2) ? 1 : $clog2(N);
    localparam int unsigned CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OWN  = 2'd2,
        ST_TURN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            br_q, br_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   hold_q, hold_d;

    logic [IW-1:0]   win_idx;
    logic [31:0]     cand;
    logic            any_req;
    logic            other_req;
    logic            own_req;
    logic            own_wr;
    logic            own_ifetch;
    logic            own_lock;
    logic [CW-1:0]   hold_inc;
    logic            preempt;
    logic            own_act;
    logic            bus_en;

    assign any_req    = |REQ;
    assign other_req  = |(REQ & ~gnt_q);
    assign own_req    = REQ[owner_q];
    assign own_wr     = WR[owner_q];
    assign own_ifetch = IFETCH[owner_q];
    assign own_lock   = LOCK[owner_q];

    // Scan order: plain index for fixed priority, rotated past the last owner for round-robin.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (MODE == 1) begin
                cand = (32'(last_q) + 32'(k) + 32'd1) % N;
            end else begin
                cand = 32'(k);
            end
            if (REQ[cand]) begin
                win_idx = IW'(cand);
            end
        end
    end

    assign hold_inc = (hold_q == CW'(HOLD_MAX)) ? hold_q : hold_q + CW'(1);
    assign preempt  = (HOLD_MAX != 0) && other_req && !own_lock
                      && (hold_inc == CW'(HOLD_MAX));

    always_comb begin
        state_d = state_q;
        br_d    = br_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    br_d    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (BA && any_req) begin
                    owner_d = win_idx;
                    last_d  = win_idx;
                    gnt_d   = N'(1) << win_idx;
                    hold_d  = '0;
                    state_d = ST_OWN;
                end else if (!any_req) begin
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (other_req) begin
                    hold_d = hold_inc;
                end
                if (!own_req || !BA || preempt) begin
                    gnt_d   = '0;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (any_req) begin
                    state_d = ST_WAIT;
                end else begin
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                br_d    = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            br_q    <= 1'b0;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Pad drive follows the owner; enables also drop the moment BA falls.
    assign own_act = (state_q == ST_OWN);
    assign bus_en  = own_act && BA;

    assign A_O   = own_act ? ADDR[32'(owner_q) * AW +: AW] : '0;
    assign D_O   = own_act ? WDATA[32'(owner_q) * DW +: DW] : '0;
    assign A_OE  = bus_en;
    assign D_OE  = bus_en && own_wr;
    assign RW_O  = bus_en && own_wr;
    assign FI_O  = bus_en && own_ifetch;
    assign DT_O  = bus_en && own_req;
    assign GNT   = gnt_q;
    assign BR    = br_q;
    assign RDATA = D_I;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against a cycle-level reference model.
module tb_bus_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned H  = 4;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_OWN = 2, PH_TURN = 3;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    REQ, LOCK, WR, IFETCH;
    logic [N*DW-1:0] WDATA;
    logic [N*AW-1:0] ADDR;
    logic [DW-1:0]   D_I;
    logic            BA;

    logic [N-1:0]  gnt   [2];
    logic [DW-1:0] rdata [2];
    logic [DW-1:0] d_o   [2];
    logic [AW-1:0] a_o   [2];
    logic          d_oe [2], a_oe [2], rw_o [2], fi_o [2], dt_o [2], br [2];

    int n_pass  = 0;
    int n_total = 0;

    int m_ph [2], m_own [2], m_last [2], m_hold [2];
    bit m_br [2];

    bus_arbiter #(.N(N), .DW(DW), .AW(AW), .MODE(0), .HOLD_MAX(H)) u_fix (
        .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .WDATA(WDATA), .ADDR(ADDR),
        .WR(WR), .IFETCH(IFETCH), .GNT(gnt[0]), .RDATA(rdata[0]), .D_I(D_I),
        .D_O(d_o[0]), .D_OE(d_oe[0]), .A_O(a_o[0]), .A_OE(a_oe[0]), .RW_O(rw_o[0]),
        .FI_O(fi_o[0]), .DT_O(dt_o[0]), .BR(br[0]), .BA(BA)
    );

    bus_arbiter #(.N(N), .DW(DW), .AW(AW), .MODE(1), .HOLD_MAX(H)) u_rr (
        .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .WDATA(WDATA), .ADDR(ADDR),
        .WR(WR), .IFETCH(IFETCH), .GNT(gnt[1]), .RDATA(rdata[1]), .D_I(D_I),
        .D_O(d_o[1]), .D_OE(d_oe[1]), .A_O(a_o[1]), .A_OE(a_oe[1]), .RW_O(rw_o[1]),
        .FI_O(fi_o[1]), .DT_O(dt_o[1]), .BR(br[1]), .BA(BA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ph[m] = PH_IDLE; m_br[m] = 1'b0; m_own[m] = 0;
            m_last[m] = int'(N) - 1; m_hold[m] = 0;
        end
    endtask

    // Winner per the rules: lowest index, or first requester after the last owner.
    function automatic int pick(input int m);
        int c;
        for (int k = 0; k < int'(N); k++) begin
            c = (m == 1) ? (m_last[m] + 1 + k) % int'(N) : k;
            if (REQ[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit any_r, others, stop;
        int nh, o;
        any_r = (REQ != '0);
        for (int m = 0; m < 2; m++) begin
            o = m_own[m];
            case (m_ph[m])
                PH_IDLE: if (any_r) begin m_br[m] = 1'b1; m_ph[m] = PH_WAIT; end
                PH_WAIT: begin
                    if (BA && any_r) begin
                        m_own[m] = pick(m); m_last[m] = m_own[m];
                        m_hold[m] = 0; m_ph[m] = PH_OWN;
                    end else if (!any_r) begin
                        m_br[m] = 1'b0; m_ph[m] = PH_IDLE;
                    end
                end
                PH_OWN: begin
                    others = 1'b0;
                    for (int i = 0; i < int'(N); i++)
                        if (i != o && REQ[i]) others = 1'b1;
                    nh = others ? ((m_hold[m] + 1 > int'(H)) ? int'(H) : m_hold[m] + 1)
                                : m_hold[m];
                    stop = !REQ[o] || !BA || (others && nh == int'(H) && !LOCK[o]);
                    m_hold[m] = nh;
                    if (stop) m_ph[m] = PH_TURN;
                end
                default: begin
                    if (any_r) m_ph[m] = PH_WAIT;
                    else begin m_br[m] = 1'b0; m_ph[m] = PH_IDLE; end
                end
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        logic [28:0]  eb, gb;
        int o;
        for (int m = 0; m < 2; m++) begin
            o  = m_own[m];
            eg = '0;
            eb = '0;
            if (m_ph[m] == PH_OWN) begin
                eg[o] = 1'b1;
                eb = {BA, WR[o] & BA, REQ[o] & BA, WR[o] & BA, IFETCH[o] & BA,
                      ADDR[o*AW +: AW], WDATA[o*DW +: DW]};
            end
            gb = {a_oe[m], d_oe[m], dt_o[m], rw_o[m], fi_o[m], a_o[m], d_o[m]};
            chk(m == 0 ? "gnt_fix" : "gnt_rr", 64'(gnt[m]), 64'(eg));
            chk(m == 0 ? "br_fix" : "br_rr", 64'(br[m]), 64'(m_br[m]));
            chk(m == 0 ? "bus_fix" : "bus_rr", 64'(gb), 64'(eb));
            chk(m == 0 ? "rdata_fix" : "rdata_rr", 64'(rdata[m]), 64'(D_I));
        end
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock,
                         input logic ba, input logic [N-1:0] wr_or);
        @(negedge CLK);
        REQ = req; LOCK = lock; BA = ba;
        WR = 4'($urandom()) | wr_or;
        IFETCH = 4'($urandom());
        WDATA = 32'($urandom());
        ADDR = {$urandom(), $urandom()};
        D_I = 8'($urandom());
        #1 check_outputs();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
    endtask

    task automatic reset_all();
        @(negedge CLK);
        RST = 1'b0; REQ = '0; LOCK = '0; BA = 1'b1;
        #2 model_reset();
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic go_idle();
        repeat (4) begin drive('0, '0, 1'b1, '0); tick(); end
    endtask

    initial begin
        logic [N-1:0] req_r, lock_r, prev;
        logic         ba_r;
        logic [N-1:0] seq [$];
        int           lens [$];
        int           cur, cnt;

        RST = 1'b0; REQ = '0; LOCK = '0; WR = '0; IFETCH = '0;
        WDATA = '0; ADDR = '0; D_I = '0; BA = 1'b1;
        model_reset();
        #1 check_outputs();
        @(negedge CLK);
        RST = 1'b1;
        tick();

        // Request-to-grant latency, fixed priority picks driver 1 of 0b0110.
        drive(4'b0110, '0, 1'b1, '0); tick();
        drive(4'b0110, '0, 1'b1, '0);
        chk("t1_br", 64'(br[0]), 64'(1));
        chk("t1_gnt_pre", 64'(gnt[0]), 64'(0));
        tick();
        drive(4'b0110, '0, 1'b1, '0);
        chk("t1_gnt", 64'(gnt[0]), 64'(4'b0010));
        chk("t1_dt", 64'(dt_o[0]), 64'(1));
        chk("t1_addr", 64'(a_o[0]), 64'(ADDR[AW +: AW]));
        tick();
        go_idle();

        // Round-robin rotation with every driver requesting.
        reset_all();
        prev = '0; cur = 0;
        for (int c = 0; c < 34; c++) begin
            drive(4'b1111, '0, 1'b1, '0);
            if (gnt[1] != '0 && prev == '0) seq.push_back(gnt[1]);
            if (gnt[1] != '0) cur++;
            else if (prev != '0) begin lens.push_back(cur); cur = 0; end
            prev = gnt[1];
            tick();
        end
        chk("rr_seq0", 64'(seq[0]), 64'(4'b0001));
        chk("rr_seq1", 64'(seq[1]), 64'(4'b0010));
        chk("rr_seq2", 64'(seq[2]), 64'(4'b0100));
        chk("rr_seq3", 64'(seq[3]), 64'(4'b1000));
        chk("rr_seq4", 64'(seq[4]), 64'(4'b0001));
        chk("rr_hold_len", 64'(lens[0]), 64'(H));
        go_idle();

        // Lock keeps driver 0 past the hold limit; driver 1 follows three cycles after release.
        cnt = 0;
        for (int c = 0; c < 22; c++) begin
            drive(4'b0011, 4'b0001, 1'b1, '0);
            if (gnt[0] == 4'b0001) cnt++;
            tick();
        end
        chk("lock_hold", 64'(cnt), 64'(20));
        for (int i = 0; i < 4; i++) begin
            drive(4'b0010, 4'b0001, 1'b1, '0);
            if (i == 2) chk("lock_next_early", 64'(gnt[0]), 64'(0));
            if (i == 3) chk("lock_next", 64'(gnt[0]), 64'(4'b0010));
            tick();
        end
        go_idle();

        // BA drops during ownership.
        for (int c = 0; c < 10; c++) begin drive(4'b0100, '0, 1'b1, '0); tick(); end
        drive(4'b0100, '0, 1'b0, '0);
        chk("ba_aoe", 64'(a_oe[0]), 64'(0));
        chk("ba_gnt_held", 64'(gnt[0]), 64'(4'b0100));
        tick();
        drive(4'b0100, '0, 1'b0, '0);
        chk("ba_gnt_drop", 64'(gnt[0]), 64'(0));
        chk("ba_br_held", 64'(br[0]), 64'(1));
        tick();
        drive(4'b0100, '0, 1'b0, '0); tick();
        drive(4'b0100, '0, 1'b1, '0); tick();
        drive(4'b0100, '0, 1'b1, '0);
        chk("ba_regrant", 64'(gnt[0]), 64'(4'b0100));
        tick();
        go_idle();

        // Asynchronous reset while driver 0 writes.
        for (int c = 0; c < 3; c++) begin
            drive(4'b0001, '0, 1'b1, 4'b0001);
            if (c == 2) chk("rst_pre_doe", 64'(d_oe[0]), 64'(1));
            if (c < 2) tick();
        end
        #1 RST = 1'b0; REQ = '0;
        #1;
        chk("rst_doe", 64'(d_oe[0]), 64'(0));
        chk("rst_gnt", 64'(gnt[0]), 64'(0));
        chk("rst_br", 64'(br[0]), 64'(0));
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        tick();
        drive(4'b1000, '0, 1'b1, '0); tick();
        drive(4'b1000, '0, 1'b1, '0); tick();
        drive(4'b1000, '0, 1'b1, '0);
        chk("rst_regrant", 64'(gnt[0]), 64'(4'b1000));
        tick();
        go_idle();

        // Requester withdrawn while waiting for BA is not granted.
        drive(4'b1001, '0, 1'b0, '0); tick();
        drive(4'b1000, '0, 1'b0, '0); tick();
        drive(4'b1000, '0, 1'b1, '0); tick();
        drive(4'b1000, '0, 1'b1, '0);
        chk("wait_drop", 64'(gnt[0]), 64'(4'b1000));
        tick();
        go_idle();

        // Randomised traffic with persistent requests, locks and BA.
        req_r = '0; lock_r = '0; ba_r = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(7) == 0) req_r[i] = ~req_r[i];
                if ($urandom_range(31) == 0) lock_r[i] = ~lock_r[i];
            end
            if ($urandom_range(9) == 0) ba_r = ~ba_r;
            drive(req_r, lock_r, ba_r, '0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
